// File: rtl/deco_pipe.sv
// deco_pipe: binary select -> one-hot decoder feeding a 2-entry skid FIFO.
// Latency: 1 cycle from push to out_dec when empty; out_dec comes straight from storage.
// Backpressure: in_ready is registered (count < 2), so there is no out_ready->in_ready path.
// Optional: define DECO_PIPE_CNT_EN to add a saturating 16-bit pop counter on port pop_cnt.
module deco_pipe #(
    parameter int SEL_W   = 2,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<SEL_W)-1:0]   out_dec
`ifdef DECO_PIPE_CNT_EN
    ,
    output logic [15:0]             pop_cnt
`endif
);

    localparam int N = 1 << SEL_W;
    // Word shown when nothing is valid; also the polarity mask applied at push.
    localparam logic [N-1:0] INACTIVE = {N{ACT_LOW}};

    logic [N-1:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d;
    logic         push, pop;
    logic [N-1:0] onehot;
    logic [N-1:0] word_in;

    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_dec   = out_valid ? mem_q[rd_ptr_q] : INACTIVE;

    // Handshakes, decoded word and next-state for pointers, count and in_ready.
    always_comb begin
        push       = in_valid & in_ready_q;
        pop        = out_valid & out_ready;
        onehot     = in_en ? ({{(N-1){1'b0}}, 1'b1} << in_sel) : '0;
        word_in    = onehot ^ INACTIVE;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        // Registered ready: held low through reset, rises on the first edge after.
        in_ready_d = (cnt_d != 2'd2);
    end

    // FIFO state; reset drops all buffered words asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= word_in;
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef DECO_PIPE_CNT_EN
    logic [15:0] pop_cnt_q, pop_cnt_d;

    assign pop_cnt = pop_cnt_q;

    // Pop counter sticks at all-ones instead of wrapping.
    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (pop && (pop_cnt_q != 16'hFFFF)) begin
            pop_cnt_d = pop_cnt_q + 16'd1;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt_q <= 16'd0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_deco_pipe.sv
// tb_deco_pipe: directed checks of deco_pipe (SEL_W=2 active-high, SEL_W=3 active-low).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Pop counter checks are built only when DECO_PIPE_CNT_EN is defined.
module tb_deco_pipe;

    logic clk;
    logic rst_n;

    logic       a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready;
    logic [1:0] a_in_sel;
    logic [3:0] a_out_dec;

    logic       b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready;
    logic [2:0] b_in_sel;
    logic [7:0] b_out_dec;

`ifdef DECO_PIPE_CNT_EN
    logic [15:0] a_pop_cnt;
    logic [15:0] b_pop_cnt;
`endif

    int n_chk;
    int n_pass;

    deco_pipe #(.SEL_W(2), .ACT_LOW(1'b0)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sel    (a_in_sel),
        .in_en     (a_in_en),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_dec   (a_out_dec)
`ifdef DECO_PIPE_CNT_EN
        ,
        .pop_cnt   (a_pop_cnt)
`endif
    );

    deco_pipe #(.SEL_W(3), .ACT_LOW(1'b1)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (b_in_sel),
        .in_en     (b_in_en),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_dec   (b_out_dec)
`ifdef DECO_PIPE_CNT_EN
        ,
        .pop_cnt   (b_pop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_push(input logic [1:0] sel, input logic en);
        a_in_valid = 1'b1;
        a_in_sel   = sel;
        a_in_en    = en;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_sel = 2'd0; a_in_en = 1'b0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_sel = 3'd0; b_in_en = 1'b0; b_out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready",   32'(a_in_ready),  0);
        chk("rst_out_valid",  32'(a_out_valid), 0);
        chk("rst_out_dec",    32'(a_out_dec),   0);
        chk("rst_b_out_dec",  32'(b_out_dec),   32'h0000_00FF);
`ifdef DECO_PIPE_CNT_EN
        chk("rst_pop_cnt",    32'(a_pop_cnt),   0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(a_in_ready), 0);
        @(negedge clk);
        chk("rdy_after_edge",  32'(a_in_ready), 1);

        // Streaming decode, out_ready held high
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 2'(i);
            a_in_en    = 1'b1;
            @(negedge clk);
            chk("stream_valid", 32'(a_out_valid), 1);
            chk("stream_dec",   32'(a_out_dec),   32'(1 << i));
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(a_out_valid), 0);
        chk("drain_dec",   32'(a_out_dec),   0);
        // Empty FIFO with out_ready=1 must not underflow
        @(negedge clk);
        chk("empty_valid", 32'(a_out_valid), 0);
        chk("empty_ready", 32'(a_in_ready),  1);

        // Disabled decode
        a_out_ready = 1'b0;
        a_push(2'd2, 1'b0);
        chk("en0_valid", 32'(a_out_valid), 1);
        chk("en0_dec",   32'(a_out_dec),   0);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("en0_popped", 32'(a_out_valid), 0);

        // Fill to 2 under backpressure
        a_out_ready = 1'b0;
        a_push(2'd1, 1'b1);
        chk("bp_ready_c1", 32'(a_in_ready), 1);
        a_push(2'd3, 1'b1);
        chk("bp_ready_full", 32'(a_in_ready), 0);
        chk("bp_head",       32'(a_out_dec),  32'h2);
        @(negedge clk);
        chk("bp_head_stable", 32'(a_out_dec), 32'h2);
        chk("bp_valid",       32'(a_out_valid), 1);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second",     32'(a_out_dec),  32'h8);
        chk("bp_ready_back", 32'(a_in_ready), 1);
        @(negedge clk);
        chk("bp_drained",    32'(a_out_valid), 0);

        // Asynchronous reset with two words buffered
        a_out_ready = 1'b0;
        a_push(2'd1, 1'b1);
        a_push(2'd3, 1'b1);
        chk("full_again", 32'(a_in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_out_valid), 0);
        chk("arst_dec",   32'(a_out_dec),   0);
        chk("arst_ready", 32'(a_in_ready),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_up", 32'(a_in_ready), 1);
        a_out_ready = 1'b1;
        a_push(2'd0, 1'b1);
        chk("post_rst_valid", 32'(a_out_valid), 1);
        chk("post_rst_dec",   32'(a_out_dec),   32'h1);
        @(negedge clk);

        // Active-low, SEL_W=3 instance
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1; b_in_sel = 3'd5; b_in_en = 1'b1;
        @(negedge clk);
        b_in_valid  = 1'b1; b_in_sel = 3'd3; b_in_en = 1'b0;
        chk("al_valid", 32'(b_out_valid), 1);
        chk("al_dec",   32'(b_out_dec),   32'h0000_00DF);
        @(negedge clk);
        b_in_valid  = 1'b0;
        chk("al_full",  32'(b_in_ready),  0);
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("al_en0_valid", 32'(b_out_valid), 1);
        chk("al_en0_dec",   32'(b_out_dec),   32'h0000_00FF);
        @(negedge clk);
        chk("al_idle_valid", 32'(b_out_valid), 0);
        chk("al_idle_dec",   32'(b_out_dec),   32'h0000_00FF);

`ifdef DECO_PIPE_CNT_EN
        // Pop counter: 10 pops, then saturation
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cnt_reset", 32'(a_pop_cnt), 0);
        a_out_ready = 1'b1;
        a_in_en     = 1'b1;
        a_in_sel    = 2'd1;
        a_in_valid  = 1'b1;
        repeat (10) @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_10", 32'(a_pop_cnt), 10);
        a_in_valid = 1'b1;
        repeat (70000) @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_sat", 32'(a_pop_cnt), 32'h0000_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/deco_pipe.md
DECO_PIPE -- requirements
Module: deco_pipe

Interface
REQ-001 The module SHALL have parameter SEL_W, default 2, giving select width, legal range 1..6.
REQ-002 The module SHALL have parameter ACT_LOW, default 0; when 1, all decoded outputs SHALL be active-low.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the upstream select word is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The module SHALL have port in_sel, input, SEL_W bits: the binary select to decode.
REQ-008 The module SHALL have port in_en, input, 1 bit: decode enable, sampled with in_sel.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_dec holds a decoded word.
REQ-010 The module SHALL have port out_ready, input, 1 bit: downstream accepts out_dec.
REQ-011 The module SHALL have port out_dec, output, 2**SEL_W bits: the one-hot decoded word.

Function
REQ-012 A push SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-013 At push, the word stored SHALL be: bit in_sel set and all other bits clear if in_en=1; all bits clear if in_en=0. When ACT_LOW=1, the stored word SHALL be bitwise inverted.
REQ-014 Decoded words SHALL be held in a 2-entry FIFO (skid buffer) with occupancy count 0..2.
REQ-015 in_ready SHALL be 1 exactly when the count is less than 2, depending only on registered state with no combinational path from out_ready.
REQ-016 out_valid SHALL be 1 exactly when the count is greater than 0; out_dec SHALL show the head entry, registered, with no combinational path from in_sel.
REQ-017 Latency SHALL be 1 cycle: a word pushed at edge N appears on out_dec with out_valid=1 after edge N, provided the FIFO was empty.
REQ-018 A simultaneous push and pop at count 1 SHALL leave the count at 1, with the new word becoming the head after the edge.
REQ-019 At count 2, in_ready=0; a pop SHALL reduce the count to 1, and in_ready SHALL rise after that edge.
REQ-020 At count 0, out_ready SHALL be ignored, and no underflow SHALL occur.
REQ-021 Words SHALL leave in push order with no loss or duplication under any in_valid/out_ready pattern.
REQ-022 While out_valid=1 and out_ready=0, out_dec SHALL remain stable.
REQ-023 When out_valid=0, out_dec SHALL show the inactive word: all 0 if ACT_LOW=0, all 1 if ACT_LOW=1.

Reset
REQ-024 While rst_n=0: count SHALL be 0, in_ready=0, out_valid=0, out_dec SHALL be the inactive word, and the storage SHALL be cleared.
REQ-025 A reset asserted mid-operation SHALL discard all buffered words immediately, asynchronously.
REQ-026 in_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro DECO_PIPE_CNT_EN SHALL control an optional pop counter.
- When defined: the module SHALL add output port pop_cnt, 16 bits, counting pops.
- Reset value: 0.
- The counter SHALL saturate at 16'hFFFF.
REQ-028 When DECO_PIPE_CNT_EN is undefined, the pop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then with SEL_W=2, push sel 0,1,2,3 with in_en=1 and out_ready=1 held. Required: out_dec = 0001, 0010, 0100, 1000 on consecutive cycles, each 1 cycle after its push.
REQ-030 Push sel=2 with in_en=0. Required: out_dec=0000 with out_valid=1.
REQ-031 Hold out_ready=0 and push sel 1 and 3. Required: in_ready=0 after the second push and out_dec=0010 stable. Then raise out_ready. Required: 0010 then 1000 are popped, and in_ready returns to 1.
REQ-032 Assert rst_n=0 with count 2. Required: out_valid=0 and out_dec=0000 immediately, without a clk edge. Then release rst_n and push sel 0. Required: out_dec=0001.
REQ-033 Build with SEL_W=3 and ACT_LOW=1, push sel=5. Required: out_dec=8'b11011111.
REQ-034 With DECO_PIPE_CNT_EN defined, perform 10 pops. Required: pop_cnt=10. Then force 70000 pops. Required: pop_cnt=16'hFFFF.
